// File: rtl/neuroset_pkg.sv
// Shared types and constants for the neuroset run controller.
// Holds the sequencer state encoding, ping-pong bases and the stage-index width helper.
package neuroset_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_GAP  = 3'd2,
        ST_FIN  = 3'd3,
        ST_ERR  = 3'd4
    } seq_state_e;

    localparam int unsigned BASE_A = 0;
    localparam int unsigned BASE_B = 4096;

    // A single-stage pipeline still needs a one-bit stage index.
    function automatic int unsigned stage_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog: counts cycles while enabled, flags when the count reaches TIMEOUT.
// Clear has priority over counting; the count parks at TIMEOUT instead of wrapping.
module stage_watchdog #(
    parameter int TW      = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + TW'(1);
        end
    end

    assign expired = (count == TW'(TIMEOUT));

endmodule

// File: rtl/layer_sequencer.sv
// Run controller: enables conv/pool/dense/result engines one at a time, waits for STOP,
// ping-pongs the pixel-memory bases between stages and aborts a stage on watchdog expiry.
module layer_sequencer
    import neuroset_pkg::*;
#(
    parameter int NUM_STAGES       = 4,
    parameter int SIZE_address_pix = 13,
    parameter int TIMEOUT          = 65535,
    parameter int TW               = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [NUM_STAGES-1:0]                stop_in,
    output logic [NUM_STAGES-1:0]                enable_out,
    output logic [SIZE_address_pix-1:0]          memstartp,
    output logic [SIZE_address_pix-1:0]          memstartzap,
    output logic [stage_width(NUM_STAGES)-1:0]   stage,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 timeout_err
);

    localparam int                    SW     = stage_width(NUM_STAGES);
    localparam logic [SW-1:0]         LAST   = SW'(NUM_STAGES - 1);
    localparam logic [SIZE_address_pix-1:0] ADDR_A = SIZE_address_pix'(BASE_A);
    localparam logic [SIZE_address_pix-1:0] ADDR_B = SIZE_address_pix'(BASE_B);

    seq_state_e state_q;
    seq_state_e next_state;

    logic                        wd_expired;
    logic [NUM_STAGES-1:0]       en_d;
    logic [SW-1:0]               stage_d;
    logic [SIZE_address_pix-1:0] mp_d;
    logic [SIZE_address_pix-1:0] mz_d;
    logic                        busy_d;
    logic                        done_d;
    logic                        terr_d;

    // The watchdog runs only while a stage holds enable and restarts on every RUN entry.
    stage_watchdog #(
        .TW      (TW),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q != ST_RUN),
        .en      (state_q == ST_RUN),
        .expired (wd_expired)
    );

    // State register; every output is registered here alongside the state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update
        // from the same pre-edge values; blocking here would create order-dependent races.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            enable_out  <= '0;
            stage       <= '0;
            memstartp   <= ADDR_A;
            memstartzap <= ADDR_B;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= next_state;
            enable_out  <= en_d;
            stage       <= stage_d;
            memstartp   <= mp_d;
            memstartzap <= mz_d;
            busy        <= busy_d;
            done        <= done_d;
            timeout_err <= terr_d;
        end
    end

    // Next-state logic: abort beats the watchdog, which beats STOP.
    always_comb begin
        next_state = state_q;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (start) next_state = ST_RUN;
                ST_RUN: begin
                    if (wd_expired)          next_state = ST_ERR;
                    else if (stop_in[stage]) next_state = ST_GAP;
                end
                // Engines clear STOP one edge after enable falls, so wait for it to drop.
                ST_GAP: begin
                    if (!stop_in[stage]) next_state = (stage == LAST) ? ST_FIN : ST_RUN;
                end
                ST_FIN:  next_state = ST_IDLE;
                ST_ERR:  next_state = ST_IDLE;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Output logic: computes the values the outputs take at the next edge.
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise paths that
        // skip an assignment would infer latches.
        en_d    = '0;
        stage_d = stage;
        mp_d    = memstartp;
        mz_d    = memstartzap;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        terr_d  = timeout_err;

        if (state_q == ST_IDLE && next_state == ST_RUN) begin
            stage_d = '0;
            mp_d    = ADDR_A;
            mz_d    = ADDR_B;
            terr_d  = 1'b0;
        end

        // Each stage reads what the previous one wrote, so the two regions trade roles.
        if (state_q == ST_GAP && next_state == ST_RUN) begin
            stage_d = stage + SW'(1);
            mp_d    = memstartzap;
            mz_d    = memstartp;
        end

        if (state_q == ST_RUN && next_state == ST_ERR) begin
            terr_d = 1'b1;
        end

        case (next_state)
            ST_RUN: begin
                en_d[stage_d] = 1'b1;
                busy_d        = 1'b1;
            end
            ST_GAP:  busy_d = 1'b1;
            ST_FIN:  done_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: directed table, multi-cycle corner sequences
// and a randomized run, all compared against a behavioural model of the run rules.
module tb_layer_sequencer;

    localparam int N   = 4;
    localparam int AW  = 13;
    localparam int TMO = 16;
    localparam int TWB = 16;
    localparam logic [AW-1:0] A_BASE = 13'd0;
    localparam logic [AW-1:0] B_BASE = 13'd4096;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_GAP  = 2;
    localparam int M_FIN  = 3;
    localparam int M_ERR  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [N-1:0]  stop_in;
    logic [N-1:0]  enable_out;
    logic [AW-1:0] memstartp;
    logic [AW-1:0] memstartzap;
    logic [1:0]    stage;
    logic          busy;
    logic          done;
    logic          timeout_err;

    layer_sequencer #(
        .NUM_STAGES       (N),
        .SIZE_address_pix (AW),
        .TIMEOUT          (TMO),
        .TW               (TWB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .stop_in     (stop_in),
        .enable_out  (enable_out),
        .memstartp   (memstartp),
        .memstartzap (memstartzap),
        .stage       (stage),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: a run walks stages 0..N-1; m_wd is the number of RUN cycles
    // already spent in the current stage when the edge samples the inputs.
    int m_mode;
    int m_stg;
    int m_wd;
    bit m_terr;

    task automatic model_step(input bit r, input bit s, input bit a, input logic [N-1:0] st);
        if (!r) begin
            m_mode = M_IDLE; m_stg = 0; m_wd = 0; m_terr = 0;
        end else if (a) begin
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (s) begin
                    m_mode = M_RUN; m_stg = 0; m_wd = 0; m_terr = 0;
                end
                M_RUN: begin
                    if (m_wd == TMO) begin
                        m_mode = M_ERR; m_terr = 1;
                    end else if (st[m_stg]) begin
                        m_mode = M_GAP;
                    end else begin
                        m_wd++;
                    end
                end
                M_GAP: if (!st[m_stg]) begin
                    if (m_stg == N - 1) begin
                        m_mode = M_FIN;
                    end else begin
                        m_stg++; m_wd = 0; m_mode = M_RUN;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] exp_en;
        logic [AW-1:0] exp_p;
        exp_en = '0;
        if (m_mode == M_RUN) exp_en[m_stg] = 1'b1;
        exp_p = (m_stg % 2 == 0) ? A_BASE : B_BASE;
        check("model enable_out", 32'(enable_out), 32'(exp_en));
        check("model stage", 32'(stage), 32'(m_stg));
        check("model memstartp", 32'(memstartp), 32'(exp_p));
        check("model memstartzap", 32'(memstartzap), 32'(exp_p ^ B_BASE));
        check("model busy", 32'(busy), 32'(m_mode == M_RUN || m_mode == M_GAP));
        check("model done", 32'(done), 32'(m_mode == M_FIN));
        check("model timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    // Engine models: raise STOP lat cycles after enable rises, release it hold cycles
    // after enable falls (registered engine, so release lands one edge later).
    int           en_cnt[N];
    int           off_cnt[N];
    int           lat[N];
    int           hold[N];
    bit           mute[N];
    logic [N-1:0] eng_stop;

    task automatic engine_reset(input int l, input int h);
        for (int i = 0; i < N; i++) begin
            en_cnt[i] = 0; off_cnt[i] = 0; lat[i] = l; hold[i] = h; mute[i] = 0;
        end
        eng_stop = '0;
    endtask

    task automatic engine_update();
        for (int i = 0; i < N; i++) begin
            if (enable_out[i]) begin
                en_cnt[i]++;
                off_cnt[i] = 0;
                if (!mute[i] && en_cnt[i] >= lat[i]) eng_stop[i] = 1'b1;
            end else begin
                en_cnt[i] = 0;
                if (eng_stop[i]) begin
                    off_cnt[i]++;
                    if (off_cnt[i] > hold[i]) begin
                        eng_stop[i] = 1'b0;
                        off_cnt[i]  = 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit a, input logic [N-1:0] st);
        rst_n = r; start = s; abort = a; stop_in = st;
        @(posedge clk);
        #1;
        model_step(r, s, a, st);
        compare_model();
        engine_update();
    endtask

    typedef struct {
        bit            r;
        bit            s;
        bit            a;
        logic [N-1:0]  st;
        logic [N-1:0]  en;
        bit            bsy;
        bit            dn;
        logic [1:0]    stg;
        bit            terr;
        logic [AW-1:0] p;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #500000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [N-1:0]  rise_en[$];
        logic [AW-1:0] rise_p[$];
        logic [N-1:0]  prev_en;
        logic [N-1:0]  exp_one;
        int            dc;
        int            hi1;
        int            gap;
        bit            seen0;
        bit            hit;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; stop_in = '0;
        m_mode = M_IDLE; m_stg = 0; m_wd = 0; m_terr = 0;
        engine_reset(5, 1);

        // Directed table: {rst_n, start, abort, stop_in} -> outputs after the edge.
        tbl[0]  = '{0, 0, 0, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, A_BASE};
        tbl[1]  = '{1, 0, 0, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, A_BASE};
        tbl[2]  = '{1, 1, 0, 4'b0000, 4'b0001, 1, 0, 2'd0, 0, A_BASE};
        tbl[3]  = '{1, 0, 0, 4'b0000, 4'b0001, 1, 0, 2'd0, 0, A_BASE};
        tbl[4]  = '{1, 0, 0, 4'b0001, 4'b0000, 1, 0, 2'd0, 0, A_BASE};
        tbl[5]  = '{1, 0, 0, 4'b0001, 4'b0000, 1, 0, 2'd0, 0, A_BASE};
        tbl[6]  = '{1, 0, 0, 4'b0000, 4'b0010, 1, 0, 2'd1, 0, B_BASE};
        tbl[7]  = '{1, 1, 0, 4'b0000, 4'b0010, 1, 0, 2'd1, 0, B_BASE};
        tbl[8]  = '{1, 0, 0, 4'b0101, 4'b0010, 1, 0, 2'd1, 0, B_BASE};
        tbl[9]  = '{1, 0, 1, 4'b0010, 4'b0000, 0, 0, 2'd1, 0, B_BASE};
        tbl[10] = '{1, 1, 1, 4'b0000, 4'b0000, 0, 0, 2'd1, 0, B_BASE};
        tbl[11] = '{1, 1, 0, 4'b0000, 4'b0001, 1, 0, 2'd0, 0, A_BASE};
        tbl[12] = '{1, 0, 1, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, A_BASE};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].st);
            check($sformatf("tbl[%0d] enable_out", i), 32'(enable_out), 32'(tbl[i].en));
            check($sformatf("tbl[%0d] busy", i), 32'(busy), 32'(tbl[i].bsy));
            check($sformatf("tbl[%0d] done", i), 32'(done), 32'(tbl[i].dn));
            check($sformatf("tbl[%0d] stage", i), 32'(stage), 32'(tbl[i].stg));
            check($sformatf("tbl[%0d] timeout_err", i), 32'(timeout_err), 32'(tbl[i].terr));
            check($sformatf("tbl[%0d] memstartp", i), 32'(memstartp), 32'(tbl[i].p));
            check($sformatf("tbl[%0d] memstartzap", i), 32'(memstartzap), 32'(tbl[i].p ^ B_BASE));
        end

        // Nominal run: STOP 5 cycles after enable, released one cycle after enable falls.
        engine_reset(5, 1);
        prev_en = '0; dc = 0;
        step(1, 1, 0, '0);
        for (int c = 0; c < 200; c++) begin
            if (enable_out != '0 && enable_out != prev_en) begin
                rise_en.push_back(enable_out);
                rise_p.push_back(memstartp);
            end
            prev_en = enable_out;
            if (done) dc++;
            if (dc > 0) break;
            step(1, 0, 0, eng_stop);
        end
        check("nominal enable rises", 32'(rise_en.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rise_en.size()) begin
                exp_one = '0;
                exp_one[i] = 1'b1;
                check($sformatf("nominal rise %0d enable", i), 32'(rise_en[i]), 32'(exp_one));
                check($sformatf("nominal rise %0d memstartp", i), 32'(rise_p[i]),
                      32'((i % 2 == 0) ? A_BASE : B_BASE));
            end
        end
        step(1, 0, 0, eng_stop);
        if (done) dc++;
        check("nominal done pulses", 32'(dc), 32'd1);
        check("nominal busy after run", 32'(busy), 32'd0);

        // Watchdog: stage 1 never stops; enable holds while the watchdog counts 0..TMO.
        engine_reset(5, 1);
        mute[1] = 1;
        hi1 = 0; dc = 0;
        step(1, 1, 0, '0);
        for (int c = 0; c < 300 && !timeout_err; c++) begin
            step(1, 0, 0, eng_stop);
            if (enable_out[1]) hi1++;
            if (done) dc++;
        end
        check("watchdog enable[1] high cycles", 32'(hi1), 32'(TMO + 1));
        check("watchdog timeout_err", 32'(timeout_err), 32'd1);
        check("watchdog enables low", 32'(enable_out), 32'd0);
        step(1, 0, 0, eng_stop);
        if (done) dc++;
        check("watchdog no done", 32'(dc), 32'd0);
        check("watchdog error sticky in idle", 32'(timeout_err), 32'd1);
        engine_reset(5, 1);
        step(1, 1, 0, '0);
        check("restart clears timeout_err", 32'(timeout_err), 32'd0);
        check("restart stage", 32'(stage), 32'd0);
        check("restart enable", 32'(enable_out), 32'b0001);
        step(1, 0, 1, '0);

        // Slow STOP release: engine 0 holds STOP 3 cycles after enable falls.
        engine_reset(5, 1);
        hold[0] = 3;
        gap = 0; seen0 = 0; hit = 0;
        step(1, 1, 0, '0);
        for (int c = 0; c < 100; c++) begin
            step(1, 0, 0, eng_stop);
            if (enable_out[1]) begin
                hit = 1;
                check("slow release STOP low at rise", 32'(stop_in[0]), 32'd0);
                break;
            end
            if (enable_out[0]) seen0 = 1;
            else if (seen0) gap++;
        end
        check("slow release stage 1 reached", 32'(hit), 32'd1);
        check("slow release gap cycles", 32'(gap), 32'd4);
        step(1, 0, 1, '0);

        // Boundary: STOP sampled with watchdog one short of TMO is still accepted.
        step(1, 1, 0, '0);
        for (int c = 0; c < TMO - 1; c++) step(1, 0, 0, '0);
        step(1, 0, 0, 4'b0001);
        check("stop before timeout busy", 32'(busy), 32'd1);
        check("stop before timeout no error", 32'(timeout_err), 32'd0);
        step(1, 0, 1, '0);

        // Conflict: STOP and watchdog==TMO together; the timeout wins.
        step(1, 1, 0, '0);
        for (int c = 0; c < TMO; c++) step(1, 0, 0, '0);
        step(1, 0, 0, 4'b0001);
        check("conflict timeout_err", 32'(timeout_err), 32'd1);
        check("conflict enables", 32'(enable_out), 32'd0);
        check("conflict busy", 32'(busy), 32'd0);
        step(1, 0, 0, '0);
        check("conflict no done", 32'(done), 32'd0);

        // Reset during stage 3 drops everything at that edge.
        engine_reset(5, 1);
        hit = 0;
        step(1, 1, 0, '0);
        for (int c = 0; c < 200; c++) begin
            if (stage == 2'd3 && enable_out[3]) begin
                hit = 1;
                break;
            end
            step(1, 0, 0, eng_stop);
        end
        check("reached stage 3", 32'(hit), 32'd1);
        step(0, 0, 0, eng_stop);
        check("mid-run reset enables", 32'(enable_out), 32'd0);
        check("mid-run reset stage", 32'(stage), 32'd0);
        check("mid-run reset busy", 32'(busy), 32'd0);
        check("mid-run reset memstartp", 32'(memstartp), 32'(A_BASE));
        check("mid-run reset memstartzap", 32'(memstartzap), 32'(B_BASE));
        step(1, 0, 0, '0);

        // Randomized traffic against the model, including noise on every STOP line.
        engine_reset(5, 1);
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] noise;
            if (m_mode == M_IDLE && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < N; i++) begin
                    lat[i]  = $urandom_range(1, 22);
                    hold[i] = $urandom_range(0, 3);
                end
            end
            noise = '0;
            for (int i = 0; i < N; i++) noise[i] = ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 199) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 39) == 0, eng_stop ^ noise);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
